// File: rtl/memory_dumper.sv
// Walks a ternary-addressed RAM region after CPU halt and streams each word
// out over valid/ready, flagging any invalid (2'b11) trit it encounters.
module memory_dumper #(
  parameter int unsigned WORD_SIZE     = 9,
  parameter int unsigned MEM_ADDR_SIZE = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start_dump,
  input  logic [2*MEM_ADDR_SIZE-1:0]   base_addr,
  input  logic [CNT_W-1:0]             word_count,
  output logic [2*MEM_ADDR_SIZE-1:0]   mem_address,
  output logic                         mem_read,
  input  logic [2*WORD_SIZE-1:0]       mem_read_data,
  output logic [2*WORD_SIZE-1:0]       out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int unsigned DW = 2 * WORD_SIZE;
  localparam int unsigned AW = 2 * MEM_ADDR_SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [AW-1:0]    addr, addr_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic [DW-1:0]    data_n;
  logic             valid_n, last_n, error_n;

  function automatic logic addr_invalid(input logic [AW-1:0] a);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < MEM_ADDR_SIZE; i++)
      if (a[2*i +: 2] == 2'b11) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic word_invalid(input logic [DW-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < WORD_SIZE; i++)
      if (w[2*i +: 2] == 2'b11) bad = 1'b1;
    return bad;
  endfunction

  // Ripple-carry ternary increment; all-2s wraps to all-0s.
  function automatic logic [AW-1:0] tern_inc(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    logic          carry;
    logic [1:0]    t;
    r     = a;
    carry = 1'b1;
    for (int unsigned i = 0; i < MEM_ADDR_SIZE; i++) begin
      t = a[2*i +: 2];
      if (carry) begin
        if (t == 2'b10) begin
          r[2*i +: 2] = 2'b00;
        end else begin
          r[2*i +: 2] = t + 2'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_last  <= last_n;
      error     <= error_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    data_n      = out_data;
    valid_n     = out_valid;
    last_n      = out_last;
    error_n     = error;
    case (state)
      S_IDLE: begin
        if (start_dump) begin
          addr_n      = base_addr;
          remaining_n = word_count;
          error_n     = 1'b0;
          if (word_count == CNT_W'(0)) begin
            state_n = S_DONE;
          end else if (addr_invalid(base_addr)) begin
            error_n = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_READ;
          end
        end
      end
      S_READ: state_n = S_WAIT;
      S_WAIT: begin
        // Read data arrives this cycle; corrupt words are still forwarded.
        data_n      = mem_read_data;
        valid_n     = 1'b1;
        last_n      = (remaining == CNT_W'(1));
        if (word_invalid(mem_read_data)) error_n = 1'b1;
        addr_n      = tern_inc(addr);
        remaining_n = remaining - CNT_W'(1);
        state_n     = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          state_n = (remaining == CNT_W'(0)) ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  assign mem_address = addr;
  assign mem_read    = (state == S_READ);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

endmodule
